// File: rtl/dwt_pkg.sv
// Shared definitions for the 2D Haar wavelet blocks: lane widths, block size,
// FSM state encoding and the pixel saturation helper.
package dwt_pkg;

   localparam int COEF_W = 8;
   localparam int PIX_W  = 8;
   localparam int BLK_N  = 8;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      COL  = 2'd1,
      ROW  = 2'd2,
      OUT  = 2'd3
   } idwt_state_e;

   // Clamp a signed value into the unsigned pixel range [0, 2^pix_w - 1].
   function automatic logic [31:0] sat_pix(input logic signed [31:0] v, input int pix_w);
      logic signed [31:0] max_v;
      max_v = (32'sd1 <<< pix_w) - 32'sd1;
      if (v < 32'sd0) begin
         sat_pix = 32'd0;
      end else if (v > max_v) begin
         sat_pix = max_v;
      end else begin
         sat_pix = v;
      end
   endfunction

endpackage

// File: rtl/idwt_2d_if.sv
// Coefficient-in / pixel-out stream bundle for idwt_2d.
interface idwt_2d_if;
   import dwt_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic [BLK_N*COEF_W-1:0]  in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [BLK_N*PIX_W-1:0]   out_data;
   logic                     out_last;
   logic                     busy;

   // Stream producer / pixel consumer side.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy
   );

   // Transform block side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, busy
   );

endinterface

// File: rtl/idwt_butterfly.sv
// Haar synthesis butterfly for one lane: sum and difference of two signed
// operands, widened by one bit so neither result can overflow.
module idwt_butterfly #(
   parameter int W = 10
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W:0]   sum,
   output logic signed [W:0]   diff
);

   assign sum  = (W+1)'(a) + (W+1)'(b);
   assign diff = (W+1)'(a) - (W+1)'(b);

endmodule

// File: rtl/idwt_2d.sv
// Inverse 2D Haar transform of one 8x8 block: load 8 coefficient rows, run a
// column synthesis pass (4 cycles) and a row synthesis pass (8 cycles) in an
// in-place flop buffer, then stream 8 saturated pixel rows out.
//
// Buffer row placement: the column pass writes X[2r] into row r and X[2r+1]
// into row r+4, so each cycle only overwrites the two rows it just read.
// Logical row j therefore lives in physical row {j[0], j[2:1]}, and the row
// pass and output stage both address through that mapping.
module idwt_2d
   import dwt_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   idwt_2d_if.slave   bus
);

   localparam int BW = COEF_W + 2;
   localparam int OW = BW + 1;

   idwt_state_e               state_r;
   idwt_state_e               state_nx_s;
   logic [2:0]                cnt_r;
   logic signed [BW-1:0]      buf_r [BLK_N][BLK_N];
   logic [BLK_N*PIX_W-1:0]    out_data_r;
   logic                      out_valid_r;
   logic                      out_last_r;
   logic                      busy_r;

   logic                      in_hs_s;
   logic                      out_hs_s;
   logic signed [BW-1:0]      bf_a_s    [BLK_N];
   logic signed [BW-1:0]      bf_b_s    [BLK_N];
   logic signed [OW-1:0]      bf_sum_s  [BLK_N];
   logic signed [OW-1:0]      bf_diff_s [BLK_N];
   logic signed [BW-1:0]      row_new_s [BLK_N];
   logic [2:0]                nxt_out_row_s;
   logic [BLK_N*PIX_W-1:0]    out_pack_s;

   // Physical buffer row holding logical row r after the column pass.
   function automatic logic [2:0] phys_row(input logic [2:0] r);
      return {r[0], r[2:1]};
   endfunction

   assign in_hs_s  = bus.in_valid && (state_r == LOAD);
   assign out_hs_s = bus.out_ready && out_valid_r;

   assign bus.in_ready  = (state_r == LOAD);
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_last  = out_last_r;
   assign bus.busy      = busy_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= LOAD;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         LOAD: begin
            if (in_hs_s && (cnt_r == 3'd7)) begin
               state_nx_s = COL;
            end else begin
               state_nx_s = LOAD;
            end
         end
         COL: begin
            if (cnt_r == 3'd3) begin
               state_nx_s = ROW;
            end else begin
               state_nx_s = COL;
            end
         end
         ROW: begin
            if (cnt_r == 3'd7) begin
               state_nx_s = OUT;
            end else begin
               state_nx_s = ROW;
            end
         end
         OUT: begin
            if (out_hs_s && (cnt_r == 3'd7)) begin
               state_nx_s = LOAD;
            end else begin
               state_nx_s = OUT;
            end
         end
         default: state_nx_s = LOAD;
      endcase
   end

   // Butterfly operand mux: column pass pairs rows r and r+4 on all lanes,
   // row pass pairs lanes k and k+4 of one row on lanes 0..3.
   always_comb begin
      for (int k = 0; k < BLK_N; k++) begin
         bf_a_s[k] = '0;
         bf_b_s[k] = '0;
      end
      case (state_r)
         COL: begin
            for (int k = 0; k < BLK_N; k++) begin
               bf_a_s[k] = buf_r[{1'b0, cnt_r[1:0]}][k];
               bf_b_s[k] = buf_r[{1'b1, cnt_r[1:0]}][k];
            end
         end
         ROW: begin
            for (int k = 0; k < BLK_N/2; k++) begin
               bf_a_s[k] = buf_r[phys_row(cnt_r)][k];
               bf_b_s[k] = buf_r[phys_row(cnt_r)][k+BLK_N/2];
            end
         end
         default: begin
         end
      endcase
   end

   for (genvar g = 0; g < BLK_N; g++) begin : g_bf
      idwt_butterfly #(.W(BW)) u_bf (
         .a    (bf_a_s[g]),
         .b    (bf_b_s[g]),
         .sum  (bf_sum_s[g]),
         .diff (bf_diff_s[g])
      );
   end

   // Row pass result: interleave sum/diff pairs and clamp to pixel range.
   always_comb begin
      for (int k = 0; k < BLK_N; k++) begin
         row_new_s[k] = '0;
      end
      for (int k = 0; k < BLK_N/2; k++) begin
         row_new_s[2*k]   = BW'(sat_pix(32'(bf_sum_s[k]), PIX_W));
         row_new_s[2*k+1] = BW'(sat_pix(32'(bf_diff_s[k]), PIX_W));
      end
   end

   // Pixel row to present next: row 0 when leaving ROW, else the row after cnt.
   always_comb begin
      out_pack_s = '0;
      if (state_r == ROW) begin
         nxt_out_row_s = phys_row(3'd0);
      end else begin
         nxt_out_row_s = phys_row(cnt_r + 3'd1);
      end
      for (int k = 0; k < BLK_N; k++) begin
         out_pack_s[k*PIX_W +: PIX_W] = buf_r[nxt_out_row_s][k][PIX_W-1:0];
      end
   end

   // Datapath: buffer loads, in-place passes, row counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= 3'd0;
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
         for (int r = 0; r < BLK_N; r++) begin
            for (int k = 0; k < BLK_N; k++) begin
               buf_r[r][k] <= '0;
            end
         end
      end else begin
         busy_r <= (state_nx_s != LOAD);
         case (state_r)
            LOAD: begin
               if (in_hs_s) begin
                  for (int k = 0; k < BLK_N; k++) begin
                     buf_r[cnt_r][k] <= BW'(signed'(bus.in_data[k*COEF_W +: COEF_W]));
                  end
                  cnt_r <= cnt_r + 3'd1;
               end
            end
            COL: begin
               for (int k = 0; k < BLK_N; k++) begin
                  buf_r[{1'b0, cnt_r[1:0]}][k] <= BW'(bf_sum_s[k]);
                  buf_r[{1'b1, cnt_r[1:0]}][k] <= BW'(bf_diff_s[k]);
               end
               if (cnt_r == 3'd3) begin
                  cnt_r <= 3'd0;
               end else begin
                  cnt_r <= cnt_r + 3'd1;
               end
            end
            ROW: begin
               for (int k = 0; k < BLK_N; k++) begin
                  buf_r[phys_row(cnt_r)][k] <= row_new_s[k];
               end
               cnt_r <= cnt_r + 3'd1;
               if (cnt_r == 3'd7) begin
                  out_valid_r <= 1'b1;
                  out_last_r  <= 1'b0;
                  out_data_r  <= out_pack_s;
               end
            end
            OUT: begin
               if (out_hs_s) begin
                  if (cnt_r == 3'd7) begin
                     cnt_r       <= 3'd0;
                     out_valid_r <= 1'b0;
                     out_last_r  <= 1'b0;
                     out_data_r  <= '0;
                  end else begin
                     cnt_r      <= cnt_r + 3'd1;
                     out_data_r <= out_pack_s;
                     out_last_r <= (cnt_r == 3'd6);
                  end
               end
            end
            default: begin
               cnt_r <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_idwt_2d.sv
// Scoreboard bench for idwt_2d: directed and random blocks are pushed through
// a behavioural inverse-Haar model into an expected-row queue; a monitor on
// the pixel stream pops and compares, and also watches stall stability and
// in_ready behaviour around the last row.
module tb_idwt_2d;
   import dwt_pkg::*;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   idwt_2d_if bus();

   idwt_2d dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   exp_t        exp_q[$];
   int          rise_q[$];
   int          blk[8][8];
   logic [63:0] rx_rows[8];
   int          rx_idx   = 0;
   int          beat7_cyc = 0;
   bit          bp_mode  = 1'b0;
   bit          prev_valid = 1'b0;
   bit          stall_pend = 1'b0;
   bit          ir_pend    = 1'b0;
   logic [63:0] hold_data;
   logic        hold_last;

   // Edge counter used for latency and period measurements.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int clamp_pix(input int v);
      if (v < 0) return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   // Reference: 1D Haar synthesis on every column (low half top, high half
   // bottom), then on every row (low half left, high half right), clamp.
   task automatic push_expected();
      int x[8][8];
      int p[8][8];
      exp_t e;
      for (int c = 0; c < 8; c++)
         for (int i = 0; i < 4; i++) begin
            x[2*i][c]   = blk[i][c] + blk[i+4][c];
            x[2*i+1][c] = blk[i][c] - blk[i+4][c];
         end
      for (int r = 0; r < 8; r++)
         for (int i = 0; i < 4; i++) begin
            p[r][2*i]   = clamp_pix(x[r][i] + x[r][i+4]);
            p[r][2*i+1] = clamp_pix(x[r][i] - x[r][i+4]);
         end
      for (int r = 0; r < 8; r++) begin
         e.data = '0;
         for (int k = 0; k < 8; k++) e.data[k*8 +: 8] = 8'(p[r][k]);
         e.last = (r == 7);
         exp_q.push_back(e);
      end
   endtask

   task automatic clear_blk();
      for (int r = 0; r < 8; r++)
         for (int k = 0; k < 8; k++) blk[r][k] = 0;
   endtask

   task automatic rand_blk();
      logic [7:0] t;
      for (int r = 0; r < 8; r++)
         for (int k = 0; k < 8; k++) begin
            t = 8'($urandom());
            blk[r][k] = int'($signed(t));
         end
   endtask

   // Drive the 8 coefficient rows; optional random in_valid bubbles.
   task automatic send_block(input bit gaps);
      int  waited;
      bit  done;
      push_expected();
      for (int r = 0; r < 8; r++) begin
         done = 1'b0;
         waited = 0;
         while (!done) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) bus.in_data[k*COEF_W +: COEF_W] = 8'(blk[r][k]);
            bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bus.in_valid && bus.in_ready) begin
               done = 1'b1;
               if (r == 7) beat7_cyc = cyc + 1;
            end
            waited++;
            if (!done && waited > 100) begin
               check("beat_accept_timeout", 72'(waited), 72'(0));
               done = 1'b1;
            end
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(exp_q.size() == 0 && bus.in_ready && !bus.out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check("idle_timeout", 72'(exp_q.size()), 72'(0));
      @(negedge clk);
   endtask

   // Output monitor: drives out_ready, pops scoreboard on each handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_valid = 1'b0;
         stall_pend = 1'b0;
         ir_pend    = 1'b0;
         rx_idx     = 0;
      end else begin
         if (stall_pend)
            check("stall_hold", {7'd0, bus.out_valid, bus.out_last, bus.out_data},
                  {7'd0, 1'b1, hold_last, hold_data});
         if (ir_pend) begin
            check("in_ready_after_last", 72'(bus.in_ready), 72'(1));
            ir_pend = 1'b0;
         end
         if (bus.out_valid)
            check("in_ready_busy_during_out", 72'({bus.in_ready, bus.busy}), 72'(2'b01));
         if (bus.out_valid && !prev_valid) rise_q.push_back(cyc);
         prev_valid = bus.out_valid;
         bus.out_ready = bp_mode ? ~bus.out_ready : 1'b1;
         stall_pend = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_row", {7'd0, bus.out_last, bus.out_data}, 72'(0) - 72'(1));
            end else begin
               e = exp_q.pop_front();
               check("row_data", {7'd0, bus.out_last, bus.out_data}, {7'd0, e.last, e.data});
            end
            rx_rows[rx_idx[2:0]] = bus.out_data;
            if (bus.out_last) begin
               rx_idx  = 0;
               ir_pend = 1'b1;
            end else begin
               rx_idx++;
            end
         end else if (bus.out_valid) begin
            stall_pend = 1'b1;
            hold_data  = bus.out_data;
            hold_last  = bus.out_last;
         end
      end
   end

   task automatic check_reset_outputs(input string name);
      check(name, {67'd0, bus.out_valid, bus.out_last, bus.busy, bus.in_ready, |bus.out_data},
            {67'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
   endtask

   task automatic set_case(input int c);
      clear_blk();
      if (c == 1) blk[0][0] = 50;
      if (c == 2) begin blk[0][0] = 100; blk[4][0] = 20; blk[0][4] = 10; end
      if (c == 3) begin blk[0][0] = 127; blk[4][0] = 127; blk[0][4] = 127; end
   endtask

   initial begin
      int t0;
      int t1;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      rst_n = 1'b1;
      @(negedge clk);

      // Case 1: DC only, plus first-row latency.
      rise_q.delete();
      set_case(1);
      send_block(1'b0);
      wait_idle();
      if (rise_q.size() > 0) check("latency_12", 72'(rise_q.pop_front() - beat7_cyc), 72'(12));
      else check("latency_no_rise", 72'(0), 72'(1));
      check("dc_row0", 72'(rx_rows[0]), 72'(64'h3232));
      check("dc_row1", 72'(rx_rows[1]), 72'(64'h3232));
      check("dc_row7", 72'(rx_rows[7]), 72'(0));

      // Case 2: mixed detail.
      set_case(2);
      send_block(1'b0);
      wait_idle();
      check("mix_row0", 72'(rx_rows[0]), 72'(64'h6E82));
      check("mix_row1", 72'(rx_rows[1]), 72'(64'h465A));

      // Case 3: saturation at both ends.
      set_case(3);
      send_block(1'b0);
      wait_idle();
      check("sat_row0", 72'(rx_rows[0]), 72'(64'h7FFF));
      check("sat_row1", 72'(rx_rows[1]), 72'(64'h007F));

      // Case 2 again with input bubbles and toggling out_ready.
      bp_mode = 1'b1;
      set_case(2);
      send_block(1'b1);
      wait_idle();
      check("bp_mix_row0", 72'(rx_rows[0]), 72'(64'h6E82));

      // Random blocks, alternating backpressure.
      for (int i = 0; i < 6; i++) begin
         bp_mode = i[0];
         rand_blk();
         send_block(1'b1);
         wait_idle();
      end
      bp_mode = 1'b0;

      // Reset during the column pass discards the block.
      set_case(2);
      send_block(1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_outputs("reset_mid_col");
      @(negedge clk);
      rst_n = 1'b1;
      set_case(1);
      send_block(1'b0);
      wait_idle();
      check("post_reset_row0", 72'(rx_rows[0]), 72'(64'h3232));
      check("post_reset_row2", 72'(rx_rows[2]), 72'(0));

      // Back-to-back blocks: output rows of consecutive blocks 28 cycles apart.
      rise_q.delete();
      set_case(1);
      send_block(1'b0);
      set_case(2);
      send_block(1'b0);
      wait_idle();
      if (rise_q.size() == 2) begin
         t0 = rise_q.pop_front();
         t1 = rise_q.pop_front();
         check("block_period_28", 72'(t1 - t0), 72'(28));
      end else begin
         check("b2b_rise_count", 72'(rise_q.size()), 72'(2));
      end
      check("b2b_row0", 72'(rx_rows[0]), 72'(64'h6E82));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
      $fatal(1);
   end

endmodule
